// File: rtl/progpow_pkg.sv
// rtl/progpow_pkg.sv - shared ProgPoW constants, index type and sequencer state encoding
package progpow_pkg;

   localparam int PROGPOW_REGS = 32;

   typedef logic [7:0] seq_idx_t;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_INIT,
      ST_FETCH_D,
      ST_MOD_D,
      ST_SWAP_D,
      ST_FETCH_S,
      ST_MOD_S,
      ST_SWAP_S,
      ST_DONE
   } seq_state_e;

endpackage

// File: rtl/progpow_seq_shuffle_if.sv
// rtl/progpow_seq_shuffle_if.sv - control, random-word stream and permutation table bundle
interface progpow_seq_shuffle_if
   import progpow_pkg::*;
#(
   parameter int NUM_REGS = PROGPOW_REGS,
   parameter int IDX_W    = $clog2(NUM_REGS)
);
   logic                      start;
   logic                      busy;
   logic                      done;
   logic                      rnd_valid;
   logic                      rnd_ready;
   logic [31:0]               rnd_data;
   logic [NUM_REGS*IDX_W-1:0] dst_seq;
   logic [NUM_REGS*IDX_W-1:0] src_seq;

   modport master (
      output start, rnd_valid, rnd_data,
      input  busy, done, rnd_ready, dst_seq, src_seq
   );

   modport slave (
      input  start, rnd_valid, rnd_data,
      output busy, done, rnd_ready, dst_seq, src_seq
   );
endinterface

// File: rtl/seq_mod_unit.sv
// rtl/seq_mod_unit.sv - 32-cycle restoring remainder, MSB first, 9-bit partial remainder
module seq_mod_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] dividend,
   input  logic [8:0]  divisor,
   output logic [8:0]  rem,
   output logic        rem_valid
);
   logic [31:0] word_q;
   logic [8:0]  divisor_q;
   logic [8:0]  rem_q;
   logic [4:0]  cnt_q;
   logic        run_q;
   logic        valid_q;

   logic [8:0]  r_cur;
   logic [8:0]  dvs;
   logic        bit_in;
   logic [9:0]  shifted;
   logic [8:0]  r_next;

   // The start edge already performs the first step, so the result lands 32 cycles after start.
   assign r_cur   = start ? 9'd0 : rem_q;
   assign dvs     = start ? divisor : divisor_q;
   assign bit_in  = start ? dividend[31] : word_q[31];
   assign shifted = {r_cur, bit_in};
   assign r_next  = (shifted >= {1'b0, dvs}) ? 9'(shifted - {1'b0, dvs}) : shifted[8:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         word_q    <= '0;
         divisor_q <= '0;
         rem_q     <= '0;
         cnt_q     <= '0;
         run_q     <= 1'b0;
         valid_q   <= 1'b0;
      end else if (start) begin
         word_q    <= {dividend[30:0], 1'b0};
         divisor_q <= divisor;
         rem_q     <= r_next;
         cnt_q     <= 5'd1;
         run_q     <= 1'b1;
         valid_q   <= 1'b0;
      end else if (run_q) begin
         word_q <= {word_q[30:0], 1'b0};
         rem_q  <= r_next;
         cnt_q  <= cnt_q + 5'd1;
         if (cnt_q == 5'd31) begin
            run_q   <= 1'b0;
            valid_q <= 1'b1;
         end
      end
   end

   assign rem       = rem_q;
   assign rem_valid = valid_q;
endmodule

// File: rtl/progpow_seq_shuffle.sv
// rtl/progpow_seq_shuffle.sv - Fisher-Yates builder of the dst/src register permutations
module progpow_seq_shuffle
   import progpow_pkg::*;
#(
   parameter int NUM_REGS = PROGPOW_REGS,
   parameter int IDX_W    = $clog2(NUM_REGS)
) (
   input logic                  clk,
   input logic                  rst,
   progpow_seq_shuffle_if.slave bus
);
   seq_state_e       state_q;
   seq_idx_t         i_q;
   logic [IDX_W-1:0] dst_q [NUM_REGS];
   logic [IDX_W-1:0] src_q [NUM_REGS];
   logic             busy_q;
   logic             done_q;
   logic             rdy_q;

   logic             mod_start;
   logic [8:0]       rem;
   logic             rem_valid;
   logic [IDX_W-1:0] i_idx;
   logic [IDX_W-1:0] j;
   logic             unused_rem;

   logic [NUM_REGS*IDX_W-1:0] dst_flat;
   logic [NUM_REGS*IDX_W-1:0] src_flat;

   // rdy_q is only ever set while in a FETCH state, so this is exactly the stream handshake.
   assign mod_start  = rdy_q && bus.rnd_valid;
   assign i_idx      = i_q[IDX_W-1:0];
   assign j          = rem[IDX_W-1:0];
   assign unused_rem = ^rem[8:IDX_W];

   seq_mod_unit u_mod (
      .clk       (clk),
      .rst       (rst),
      .start     (mod_start),
      .dividend  (bus.rnd_data),
      .divisor   ({1'b0, i_q} + 9'd1),
      .rem       (rem),
      .rem_valid (rem_valid)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         i_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         rdy_q   <= 1'b0;
         for (int k = 0; k < NUM_REGS; k++) begin
            dst_q[k] <= IDX_W'(k);
            src_q[k] <= IDX_W'(k);
         end
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  state_q <= ST_INIT;
                  busy_q  <= 1'b1;
               end
            end
            ST_INIT: begin
               for (int k = 0; k < NUM_REGS; k++) begin
                  dst_q[k] <= IDX_W'(k);
                  src_q[k] <= IDX_W'(k);
               end
               i_q     <= seq_idx_t'(NUM_REGS - 1);
               rdy_q   <= 1'b1;
               state_q <= ST_FETCH_D;
            end
            ST_FETCH_D, ST_FETCH_S: begin
               if (bus.rnd_valid) begin
                  rdy_q   <= 1'b0;
                  state_q <= (state_q == ST_FETCH_D) ? ST_MOD_D : ST_MOD_S;
               end
            end
            ST_MOD_D: if (rem_valid) state_q <= ST_SWAP_D;
            ST_MOD_S: if (rem_valid) state_q <= ST_SWAP_S;
            ST_SWAP_D: begin
               dst_q[i_idx] <= dst_q[j];
               dst_q[j]     <= dst_q[i_idx];
               rdy_q        <= 1'b1;
               state_q      <= ST_FETCH_S;
            end
            ST_SWAP_S: begin
               src_q[i_idx] <= src_q[j];
               src_q[j]     <= src_q[i_idx];
               if (i_q == 8'd1) begin
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end else begin
                  i_q     <= i_q - 8'd1;
                  rdy_q   <= 1'b1;
                  state_q <= ST_FETCH_D;
               end
            end
            ST_DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      dst_flat = '0;
      src_flat = '0;
      for (int k = 0; k < NUM_REGS; k++) begin
         dst_flat[k*IDX_W +: IDX_W] = dst_q[k];
         src_flat[k*IDX_W +: IDX_W] = src_q[k];
      end
   end

   assign bus.dst_seq   = dst_flat;
   assign bus.src_seq   = src_flat;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.rnd_ready = rdy_q;
endmodule

// File: tb/tb_progpow_seq_shuffle.sv
// tb/tb_progpow_seq_shuffle.sv - self-checking bench for the permutation builder and remainder unit
module tb_progpow_seq_shuffle;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_err;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   progpow_seq_shuffle_if #(.NUM_REGS(4))  if4 ();
   progpow_seq_shuffle_if #(.NUM_REGS(32)) if32 ();

   progpow_seq_shuffle #(.NUM_REGS(4))  u_dut4  (.clk(clk), .rst(rst), .bus(if4.slave));
   progpow_seq_shuffle #(.NUM_REGS(32)) u_dut32 (.clk(clk), .rst(rst), .bus(if32.slave));

   logic        m_start;
   logic [31:0] m_dvd;
   logic [8:0]  m_dvs;
   logic [8:0]  m_rem;
   logic        m_valid;

   seq_mod_unit u_mod (
      .clk(clk), .rst(rst), .start(m_start), .dividend(m_dvd),
      .divisor(m_dvs), .rem(m_rem), .rem_valid(m_valid)
   );

   logic [31:0] mw  [$];
   logic [31:0] q4  [$];
   logic [31:0] q32 [$];
   int          hs4, hs32, stall_n;
   int          exp_d [256];
   int          exp_s [256];
   logic [31:0] kz, kw, kjsr, kjc;

   typedef struct { logic [31:0] dvd; logic [8:0] dvs; logic [8:0] rem; } mvec_t;
   typedef struct { logic [31:0] word; logic [7:0] tab; int stall; } vec_t;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, expv);
      end
   endtask

   task automatic chk_tab(input string nm, input logic [2047:0] v, input int n, input int w,
                          input int e [256]);
      int       bad;
      logic [7:0] got;
      logic [7:0] bad_got;
      bad = -1;
      bad_got = '0;
      for (int k = 0; k < n; k++) begin
         got = 8'(v >> (k * w)) & 8'((1 << w) - 1);
         if (bad < 0 && got !== 8'(e[k])) begin
            bad = k;
            bad_got = got;
         end
      end
      n_checks++;
      if (bad >= 0) begin
         n_err++;
         $display("FAIL %s: entry %0d got %0d expected %0d", nm, bad, bad_got, e[bad]);
      end
   endtask

   function automatic logic [31:0] fnv1a(input logic [31:0] h, input logic [31:0] d);
      return (h ^ d) * 32'h0100_0193;
   endfunction

   task automatic kiss_next(output logic [31:0] r);
      logic [31:0] mwc;
      kz   = 32'd36969 * (kz & 32'h0000_FFFF) + (kz >> 16);
      kw   = 32'd18000 * (kw & 32'h0000_FFFF) + (kw >> 16);
      mwc  = (kz << 16) + kw;
      kjsr = kjsr ^ (kjsr << 17);
      kjsr = kjsr ^ (kjsr >> 13);
      kjsr = kjsr ^ (kjsr << 5);
      kjc  = 32'd69069 * kjc + 32'd1234567;
      r    = (mwc ^ kjc) + kjsr;
   endtask

   task automatic set_identity();
      for (int k = 0; k < 256; k++) begin
         exp_d[k] = k;
         exp_s[k] = k;
      end
   endtask

   // Straight software Fisher-Yates over the word list, dst word then src word per index.
   task automatic model(input int n);
      int p, j, t;
      set_identity();
      p = 0;
      for (int i = n - 1; i >= 1; i--) begin
         j = int'(mw[p] % 32'(i + 1)); p++;
         t = exp_d[i]; exp_d[i] = exp_d[j]; exp_d[j] = t;
         j = int'(mw[p] % 32'(i + 1)); p++;
         t = exp_s[i]; exp_s[i] = exp_s[j]; exp_s[j] = t;
      end
   endtask

   // mode 0: constant pattern, 1: $urandom, 2: KISS99 seeded from FNV1a(offset basis, 0)
   task automatic prep(input bit big, input int mode, input logic [31:0] pat);
      int          n;
      logic [31:0] wd;
      n = big ? 32 : 4;
      mw.delete();
      if (mode == 2) begin
         kz = fnv1a(32'h811C_9DC5, 32'h0);
         kw = kz; kjsr = kz; kjc = kz;
      end
      for (int k = 0; k < 2 * (n - 1); k++) begin
         if (mode == 0)      wd = pat;
         else if (mode == 1) wd = $urandom;
         else                kiss_next(wd);
         mw.push_back(wd);
      end
      model(n);
      if (big) begin q32 = mw; hs32 = 0; end
      else     begin q4 = mw;  hs4 = 0;  end
   endtask

   function automatic logic get_done(input bit big); return big ? if32.done : if4.done; endfunction
   function automatic logic get_busy(input bit big); return big ? if32.busy : if4.busy; endfunction

   task automatic set_start(input bit big, input logic v);
      if (big) if32.start = v;
      else     if4.start = v;
   endtask

   task automatic run(input bit big, input int pulse_at, input int exp_cyc, input string nm);
      int cyc, n, w;
      n = big ? 32 : 4;
      w = big ? 5 : 2;
      @(negedge clk); set_start(big, 1'b1);
      @(negedge clk); set_start(big, 1'b0);
      cyc = 1;
      while (!get_done(big) && cyc < 20000) begin
         set_start(big, cyc == pulse_at);
         @(negedge clk);
         cyc++;
      end
      set_start(big, 1'b0);
      chk({nm, " done latency"}, 64'(cyc), 64'(exp_cyc));
      chk({nm, " busy with done"}, 64'(get_busy(big)), 64'd1);
      set_start(big, 1'b1);
      @(negedge clk);
      set_start(big, 1'b0);
      chk({nm, " idle after done"}, {62'd0, get_busy(big), get_done(big)}, 64'd0);
      chk_tab({nm, " dst_seq"}, big ? 2048'(if32.dst_seq) : 2048'(if4.dst_seq), n, w, exp_d);
      chk_tab({nm, " src_seq"}, big ? 2048'(if32.src_seq) : 2048'(if4.src_seq), n, w, exp_s);
      chk({nm, " handshakes"}, 64'(big ? hs32 : hs4), 64'(2 * (n - 1)));
   endtask

   initial begin
      int gap;
      gap = 0; if4.rnd_valid = 1'b0; if4.rnd_data = '0;
      forever begin
         @(negedge clk);
         if (if4.rnd_ready && !rst) begin
            if (gap < stall_n) begin
               gap++; if4.rnd_valid = 1'b0;
            end else begin
               if4.rnd_valid = 1'b1;
               if4.rnd_data  = (q4.size() > 0) ? q4.pop_front() : 32'h0;
               hs4++;
            end
         end else begin
            gap = 0; if4.rnd_valid = 1'b0;
         end
      end
   end

   initial begin
      int gap;
      gap = 0; if32.rnd_valid = 1'b0; if32.rnd_data = '0;
      forever begin
         @(negedge clk);
         if (if32.rnd_ready && !rst) begin
            if (gap < stall_n) begin
               gap++; if32.rnd_valid = 1'b0;
            end else begin
               if32.rnd_valid = 1'b1;
               if32.rnd_data  = (q32.size() > 0) ? q32.pop_front() : 32'h0;
               hs32++;
            end
         end else begin
            gap = 0; if32.rnd_valid = 1'b0;
         end
      end
   end

   initial begin
      mvec_t mvecs [6];
      vec_t  vecs  [5];
      int    cyc;

      mvecs[0] = '{32'd1000,      9'd7,   9'd6};
      mvecs[1] = '{32'hFFFF_FFFF, 9'd32,  9'd31};
      mvecs[2] = '{32'hFFFF_FFFF, 9'd3,   9'd0};
      mvecs[3] = '{32'h1234_5678, 9'd256, 9'd120};
      mvecs[4] = '{32'h8000_0000, 9'd255, 9'd128};
      mvecs[5] = '{32'd9,         9'd10,  9'd9};

      vecs[0] = '{32'h0000_0000, 8'h39, 0};
      vecs[1] = '{32'hFFFF_FFFF, 8'hC6, 0};
      vecs[2] = '{32'h0000_0000, 8'h39, 5};
      vecs[3] = '{32'h0000_0001, 8'h78, 1};
      vecs[4] = '{32'h0000_0002, 8'hB1, 2};

      n_checks = 0; n_err = 0; stall_n = 0; hs4 = 0; hs32 = 0;
      rst = 1'b1; if4.start = 1'b0; if32.start = 1'b0;
      m_start = 1'b0; m_dvd = '0; m_dvs = '0;
      repeat (3) @(negedge clk);

      set_identity();
      chk("reset ctl n4",  {61'd0, if4.busy, if4.done, if4.rnd_ready}, 64'd0);
      chk("reset ctl n32", {61'd0, if32.busy, if32.done, if32.rnd_ready}, 64'd0);
      chk("reset rem_valid", 64'(m_valid), 64'd0);
      chk_tab("reset dst n4",  2048'(if4.dst_seq), 4, 2, exp_d);
      chk_tab("reset src n4",  2048'(if4.src_seq), 4, 2, exp_s);
      chk_tab("reset dst n32", 2048'(if32.dst_seq), 32, 5, exp_d);
      chk_tab("reset src n32", 2048'(if32.src_seq), 32, 5, exp_s);
      rst = 1'b0;

      for (int v = 0; v < 6; v++) begin
         @(negedge clk);
         m_start = 1'b1; m_dvd = mvecs[v].dvd; m_dvs = mvecs[v].dvs;
         @(negedge clk);
         m_start = 1'b0;
         cyc = 1;
         while (!m_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
         end
         chk($sformatf("mod%0d latency", v), 64'(cyc), 64'd32);
         chk($sformatf("mod%0d rem", v), 64'(m_rem), 64'(mvecs[v].rem));
      end

      for (int v = 0; v < 5; v++) begin
         stall_n = vecs[v].stall;
         prep(1'b0, 0, vecs[v].word);
         for (int k = 0; k < 4; k++) begin
            exp_d[k] = int'((vecs[v].tab >> (2 * k)) & 8'h3);
            exp_s[k] = exp_d[k];
         end
         run(1'b0, -1, 206 + 6 * vecs[v].stall, $sformatf("vec%0d", v));
      end

      for (int r = 0; r < 4; r++) begin
         stall_n = $urandom_range(0, 3);
         prep(1'b0, 1, 32'h0);
         run(1'b0, -1, 206 + 6 * stall_n, $sformatf("rand4_%0d", r));
      end

      stall_n = 0;
      prep(1'b1, 2, 32'h0);
      run(1'b1, -1, 2110, "kiss99 n32");

      stall_n = 5;
      prep(1'b1, 1, 32'h0);
      run(1'b1, -1, 2110 + 5 * 62, "rand n32 stall5");

      stall_n = 0;
      prep(1'b0, 1, 32'h0);
      @(negedge clk); if4.start = 1'b1;
      @(negedge clk); if4.start = 1'b0;
      repeat (99) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      set_identity();
      chk("mid-run reset ctl", {61'd0, if4.busy, if4.done, if4.rnd_ready}, 64'd0);
      chk_tab("mid-run reset dst", 2048'(if4.dst_seq), 4, 2, exp_d);
      chk_tab("mid-run reset src", 2048'(if4.src_seq), 4, 2, exp_s);
      rst = 1'b0;
      prep(1'b0, 1, 32'h0);
      run(1'b0, -1, 206, "after reset");

      prep(1'b0, 1, 32'h0);
      run(1'b0, 50, 206, "start in busy");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
